cache_ctrl_fsm: RTL

Sequencing controller for the 4-way set-associative cache datapath: tag array, data array, hit/miss logic, LFU counters and comparator, and the CPU/RAM input mux.
- Accepts one CPU request at a time (run/RW).
- Drives the array read/write enables in the right cycles.
- Performs line refill from RAM on a miss. Policy is write-allocate, write-through.
- Signals completion to the CPU and keeps hit/miss statistics.
- Sits between the CPU request interface and the cache top level, replacing ad-hoc control.

---
 rtl/cache_ctrl_fsm.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/cache_ctrl_fsm.sv
// Sequencing controller for the 4-way set-associative cache: CPU request handshake,
// array enables, write-allocate / write-through refill and hit/miss statistics.
module cache_ctrl_fsm #(
    parameter int INIT_CYCLES = 4,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             RW,
    input  logic             hit,
    input  logic             mem_ack,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             SelecMemCPU,
    output logic             ReadEnableTag,
    output logic             ReadEnableData,
    output logic             gen_reset,
    output logic             write_enable_ram,
    output logic             write_enable_cpu,
    output logic             enable_contadores,
    output logic             count_read,
    output logic             mem_req,
    output logic             mem_we,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);
    localparam int INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam int TO_W   = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    typedef enum logic [3:0] {
        S_INIT     = 4'd0,
        S_IDLE     = 4'd1,
        S_LOOKUP   = 4'd2,
        S_COMPARE  = 4'd3,
        S_FILL_REQ = 4'd4,
        S_FILL     = 4'd5,
        S_WR_WORD  = 4'd6,
        S_WT_REQ   = 4'd7,
        S_RESP     = 4'd8,
        S_ERR      = 4'd9
    } state_t;

    typedef struct packed {
        logic busy;
        logic done;
        logic err;
        logic sel_cpu;
        logic re_tag;
        logic re_data;
        logic gen_reset;
        logic we_ram;
        logic we_cpu;
        logic en_cnt;
        logic count_read;
        logic mem_req;
        logic mem_we;
    } ctrl_t;

    // Moore decode; the RESP counter pulse belongs only to reads since writes
    // already bumped the hit way in WR_WORD.
    function automatic ctrl_t decode_ctrl(input state_t st, input logic rw);
        ctrl_t c;
        c      = '0;
        c.busy = (st != S_IDLE);
        case (st)
            S_INIT:     c.gen_reset = 1'b1;
            S_IDLE:     c.busy = 1'b0;
            S_LOOKUP: begin
                c.re_tag     = 1'b1;
                c.re_data    = 1'b1;
                c.count_read = 1'b1;
            end
            S_COMPARE:  c.busy = 1'b1;
            S_FILL_REQ: c.mem_req = 1'b1;
            S_FILL: begin
                c.we_ram = 1'b1;
                c.en_cnt = 1'b1;
            end
            S_WR_WORD: begin
                c.sel_cpu = 1'b1;
                c.we_cpu  = 1'b1;
                c.en_cnt  = 1'b1;
            end
            S_WT_REQ: begin
                c.mem_req = 1'b1;
                c.mem_we  = 1'b1;
            end
            S_RESP: begin
                c.done   = 1'b1;
                c.en_cnt = ~rw;
            end
            S_ERR: begin
                c.done = 1'b1;
                c.err  = 1'b1;
            end
            default:    c.gen_reset = 1'b1;
        endcase
        return c;
    endfunction

    state_t             state_r, state_s;
    logic [INIT_W-1:0]  init_cnt_r, init_cnt_s;
    logic [TO_W-1:0]    to_cnt_r, to_cnt_s;
    logic               retry_r, retry_s;
    logic               rw_r, rw_s;
    logic [CNT_W-1:0]   hit_count_r, hit_count_s;
    logic [CNT_W-1:0]   miss_count_r, miss_count_s;
    ctrl_t              ctrl_r;

    // Next-state, bookkeeping counters and saturating statistics.
    always_comb begin
        state_s      = state_r;
        init_cnt_s   = init_cnt_r;
        to_cnt_s     = to_cnt_r;
        retry_s      = retry_r;
        rw_s         = rw_r;
        hit_count_s  = hit_count_r;
        miss_count_s = miss_count_r;
        case (state_r)
            S_INIT: begin
                if (init_cnt_r == INIT_W'(INIT_CYCLES - 1)) begin
                    state_s    = S_IDLE;
                    init_cnt_s = '0;
                end else begin
                    init_cnt_s = init_cnt_r + INIT_W'(1);
                end
            end
            S_IDLE: begin
                if (run) begin
                    rw_s    = RW;
                    retry_s = 1'b0;
                    state_s = S_LOOKUP;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_LOOKUP: state_s = S_COMPARE;
            S_COMPARE: begin
                if (retry_r) begin
                    hit_count_s = hit_count_r;
                end else if (hit) begin
                    hit_count_s = (&hit_count_r) ? hit_count_r : hit_count_r + CNT_W'(1);
                end else begin
                    miss_count_s = (&miss_count_r) ? miss_count_r : miss_count_r + CNT_W'(1);
                end
                if (hit) begin
                    state_s = rw_r ? S_WR_WORD : S_RESP;
                end else if (retry_r) begin
                    state_s = S_ERR;
                end else begin
                    state_s  = S_FILL_REQ;
                    to_cnt_s = '0;
                end
            end
            S_FILL_REQ, S_WT_REQ: begin
                // An ack in the final allowed cycle still counts as success.
                if (mem_ack) begin
                    state_s = (state_r == S_FILL_REQ) ? S_FILL : S_RESP;
                end else if (to_cnt_r == TO_W'(MEM_TIMEOUT - 1)) begin
                    state_s = S_ERR;
                end else begin
                    to_cnt_s = to_cnt_r + TO_W'(1);
                end
            end
            S_FILL: begin
                retry_s = 1'b1;
                state_s = S_LOOKUP;
            end
            S_WR_WORD: begin
                to_cnt_s = '0;
                state_s  = S_WT_REQ;
            end
            S_RESP:  state_s = S_IDLE;
            S_ERR:   state_s = S_IDLE;
            default: state_s = S_INIT;
        endcase
    end

    // State and registered control outputs (decoded from the upcoming state).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= S_INIT;
            init_cnt_r   <= '0;
            to_cnt_r     <= '0;
            retry_r      <= 1'b0;
            rw_r         <= 1'b0;
            hit_count_r  <= '0;
            miss_count_r <= '0;
            ctrl_r       <= decode_ctrl(S_INIT, 1'b0);
        end else begin
            state_r      <= state_s;
            init_cnt_r   <= init_cnt_s;
            to_cnt_r     <= to_cnt_s;
            retry_r      <= retry_s;
            rw_r         <= rw_s;
            hit_count_r  <= hit_count_s;
            miss_count_r <= miss_count_s;
            ctrl_r       <= decode_ctrl(state_s, rw_s);
        end
    end

    assign busy              = ctrl_r.busy;
    assign done              = ctrl_r.done;
    assign err               = ctrl_r.err;
    assign SelecMemCPU       = ctrl_r.sel_cpu;
    assign ReadEnableTag     = ctrl_r.re_tag;
    assign ReadEnableData    = ctrl_r.re_data;
    assign gen_reset         = ctrl_r.gen_reset;
    assign write_enable_ram  = ctrl_r.we_ram;
    assign write_enable_cpu  = ctrl_r.we_cpu;
    assign enable_contadores = ctrl_r.en_cnt;
    assign count_read        = ctrl_r.count_read;
    assign mem_req           = ctrl_r.mem_req;
    assign mem_we            = ctrl_r.mem_we;
    assign hit_count         = hit_count_r;
    assign miss_count        = miss_count_r;

endmodule
